arm_shifter_stage: RTL and testbench

Operand-2 generation stage feeding the ALU directly: decodes immediate-rotate and register-shift forms of the data-processing operand 2, applies the ARM barrel shift, and registers alu_op1, alu_op2, alu_op_sel and shifter_carry for the ALU. Register-specified shifts take one extra cycle because the Rs value arrives one cycle after acceptance from the second register-file read port. A valid/ready handshake on both sides supports decode stalls and ALU-side back-pressure.

---
 rtl/arm_shifter_stage.sv | 177 +++++++++++++++++
 tb/tb_arm_shifter_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_shifter_stage.sv
// Operand-2 generation stage: decodes immediate-rotate and shifted-register
// forms of operand 2, applies the barrel shift and registers the ALU bundle.
// Register-specified shifts wait one cycle for Rs from the second read port.
module arm_shifter_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        imm_sel,
    input  logic [7:0]  imm8,
    input  logic [3:0]  rot4,
    input  logic [31:0] rm_data,
    input  logic [1:0]  shift_type,
    input  logic        shift_by_reg,
    input  logic [4:0]  shift_imm,
    input  logic [31:0] rs_data,
    input  logic        c_in,
    input  logic [31:0] op1_in,
    input  logic [3:0]  op_sel_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [3:0]  alu_op_sel,
    output logic        shifter_carry
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RS_WAIT = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] alu_op1_q, alu_op1_d;
    logic [31:0] alu_op2_q, alu_op2_d;
    logic [3:0]  alu_op_sel_q, alu_op_sel_d;
    logic        carry_q, carry_d;
    logic [31:0] pend_rm_q, pend_rm_d;
    logic [1:0]  pend_type_q, pend_type_d;
    logic        pend_c_q, pend_c_d;

    logic        accept;
    logic [7:0]  imm_amt;
    logic [32:0] direct_res;

    // Only Rs[7:0] carries the shift amount.
    logic unused_rs;
    assign unused_rs = ^rs_data[31:8];

    // Barrel shift by an 8-bit amount with register-shift semantics.
    // Returns {carry, result}; amt == 0 passes rm through with carry c.
    function automatic logic [32:0] shift_amt(input logic [31:0] rm, input logic [1:0] st,
                                              input logic [7:0] amt, input logic c);
        logic [32:0] t;
        logic [32:0] tmp;
        logic [31:0] rot;
        logic [4:0]  r;
        t = {c, rm};
        r = amt[4:0];
        if (amt != 8'd0) begin
            case (st)
                2'b00: begin
                    if (amt < 8'd32)       t = {1'b0, rm} << r;
                    else if (amt == 8'd32) t = {rm[0], 32'd0};
                    else                   t = 33'd0;
                end
                2'b01: begin
                    if (amt < 8'd32) begin
                        tmp = {rm, 1'b0} >> r;
                        t   = {tmp[0], tmp[32:1]};
                    end else if (amt == 8'd32) begin
                        t = {rm[31], 32'd0};
                    end else begin
                        t = 33'd0;
                    end
                end
                2'b10: begin
                    if (amt < 8'd32) begin
                        tmp = $signed({rm, 1'b0}) >>> r;
                        t   = {tmp[0], tmp[32:1]};
                    end else begin
                        t = {rm[31], {32{rm[31]}}};
                    end
                end
                default: begin
                    if (r == 5'd0) begin
                        t = {rm[31], rm};
                    end else begin
                        rot = (rm >> r) | (rm << (6'd32 - {1'b0, r}));
                        t   = {rot[31], rot};
                    end
                end
            endcase
        end
        return t;
    endfunction

    // Operand 2 for bundles that complete in one cycle (immediate or shift_imm).
    always_comb begin
        logic [31:0] v;
        logic [4:0]  rot;
        // #0 for LSR/ASR encodes a shift by 32; ROR #0 (RRX) is handled below.
        imm_amt = (shift_imm == 5'd0 && shift_type != 2'b00) ? 8'd32 : {3'd0, shift_imm};
        rot     = {rot4, 1'b0};
        v       = {24'd0, imm8};
        if (imm_sel) begin
            if (rot4 != 4'd0) v = (v >> rot) | (v << (6'd32 - {1'b0, rot}));
            direct_res = {(rot4 == 4'd0) ? c_in : v[31], v};
        end else if (shift_type == 2'b11 && shift_imm == 5'd0) begin
            direct_res = {rm_data[0], c_in, rm_data[31:1]};
        end else begin
            direct_res = shift_amt(rm_data, shift_type, imm_amt, c_in);
        end
    end

    // Handshake and next-state for the bundle registers.
    always_comb begin
        in_ready     = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
        accept       = in_valid & in_ready;
        state_d      = state_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        alu_op_sel_d = alu_op_sel_q;
        carry_d      = carry_q;
        pend_rm_d    = pend_rm_q;
        pend_type_d  = pend_type_q;
        pend_c_d     = pend_c_q;
        if (state_q == RS_WAIT) begin
            {carry_d, alu_op2_d} = shift_amt(pend_rm_q, pend_type_q, rs_data[7:0], pend_c_q);
            state_d = HOLD;
        end else if (accept) begin
            // op1/op_sel are not visible while waiting for Rs, so load them now.
            alu_op1_d    = op1_in;
            alu_op_sel_d = op_sel_in;
            if (!imm_sel && shift_by_reg) begin
                pend_rm_d   = rm_data;
                pend_type_d = shift_type;
                pend_c_d    = c_in;
                state_d     = RS_WAIT;
            end else begin
                {carry_d, alu_op2_d} = direct_res;
                state_d = HOLD;
            end
        end else if (state_q == HOLD && out_ready) begin
            state_d = IDLE;
        end
    end

    // State and bundle registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            alu_op1_q    <= 32'd0;
            alu_op2_q    <= 32'd0;
            alu_op_sel_q <= 4'd0;
            carry_q      <= 1'b0;
            pend_rm_q    <= 32'd0;
            pend_type_q  <= 2'd0;
            pend_c_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            alu_op_sel_q <= alu_op_sel_d;
            carry_q      <= carry_d;
            pend_rm_q    <= pend_rm_d;
            pend_type_q  <= pend_type_d;
            pend_c_q     <= pend_c_d;
        end
    end

    assign out_valid     = (state_q == HOLD);
    assign alu_op1       = alu_op1_q;
    assign alu_op2       = alu_op2_q;
    assign alu_op_sel    = alu_op_sel_q;
    assign shifter_carry = carry_q;

endmodule

// File: tb/tb_arm_shifter_stage.sv
// Self-checking bench for arm_shifter_stage: directed cases plus randomized
// bundles compared against a bit-level reference model of operand-2 rules.
module tb_arm_shifter_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, imm_sel, shift_by_reg, c_in;
    logic [7:0]  imm8;
    logic [3:0]  rot4, op_sel_in, alu_op_sel;
    logic [31:0] rm_data, rs_data, op1_in, alu_op1, alu_op2;
    logic [1:0]  shift_type;
    logic [4:0]  shift_imm;
    logic        out_valid, out_ready, shifter_carry;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        isel;
        logic [7:0]  imm8;
        logic [3:0]  rot4;
        logic [31:0] rm;
        logic [1:0]  st;
        logic        byreg;
        logic [4:0]  simm;
        logic [31:0] rs;
        logic        c;
        logic [31:0] op1;
        logic [3:0]  opsel;
    } bundle_t;

    arm_shifter_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .imm_sel(imm_sel), .imm8(imm8), .rot4(rot4), .rm_data(rm_data),
        .shift_type(shift_type), .shift_by_reg(shift_by_reg), .shift_imm(shift_imm),
        .rs_data(rs_data), .c_in(c_in), .op1_in(op1_in), .op_sel_in(op_sel_in),
        .out_valid(out_valid), .out_ready(out_ready), .alu_op1(alu_op1),
        .alu_op2(alu_op2), .alu_op_sel(alu_op_sel), .shifter_carry(shifter_carry)
    );

    always #5 clk = ~clk;

    // Reference: {carry, result} built bit by bit from the architectural rules.
    function automatic logic [32:0] model(input bundle_t b);
        logic [31:0] res;
        logic        cy;
        int          a;
        int          r;
        res = '0;
        cy  = 1'b0;
        if (b.isel) begin
            res = {24'd0, b.imm8};
            for (int k = 0; k < 2 * int'(b.rot4); k++) res = {res[0], res[31:1]};
            cy = (b.rot4 == 4'd0) ? b.c : res[31];
            return {cy, res};
        end
        if (b.byreg) begin
            a = int'(b.rs[7:0]);
            if (a == 0) return {b.c, b.rm};
        end else begin
            a = int'(b.simm);
            if (a == 0) begin
                if (b.st == 2'd0) return {b.c, b.rm};
                if (b.st == 2'd3) return {b.rm[0], b.c, b.rm[31:1]};
                a = 32;
            end
        end
        case (b.st)
            2'd0: begin
                for (int i = 0; i < 32; i++) if (i >= a) res[i] = b.rm[i - a];
                if (a <= 32) cy = b.rm[32 - a];
            end
            2'd1: begin
                for (int i = 0; i < 32; i++) if (i + a < 32) res[i] = b.rm[i + a];
                if (a <= 32) cy = b.rm[a - 1];
            end
            2'd2: begin
                for (int i = 0; i < 32; i++) res[i] = (i + a < 32) ? b.rm[i + a] : b.rm[31];
                cy = (a <= 32) ? b.rm[a - 1] : b.rm[31];
            end
            default: begin
                r = a % 32;
                if (r == 0) begin
                    res = b.rm;
                    cy  = b.rm[31];
                end else begin
                    for (int i = 0; i < 32; i++) res[i] = b.rm[(i + r) % 32];
                    cy = b.rm[r - 1];
                end
            end
        endcase
        return {cy, res};
    endfunction

    function automatic bundle_t mk(input logic isel, input logic [7:0] i8, input logic [3:0] r4,
                                   input logic [31:0] rm, input logic [1:0] st,
                                   input logic byreg, input logic [4:0] simm,
                                   input logic [31:0] rs, input logic c);
        bundle_t b;
        b.isel = isel; b.imm8 = i8; b.rot4 = r4; b.rm = rm; b.st = st;
        b.byreg = byreg; b.simm = simm; b.rs = rs; b.c = c;
        b.op1 = 32'hDEADBEEF; b.opsel = 4'hD;
        return b;
    endfunction

    task automatic drive(input bundle_t b);
        imm_sel = b.isel; imm8 = b.imm8; rot4 = b.rot4; rm_data = b.rm;
        shift_type = b.st; shift_by_reg = b.byreg; shift_imm = b.simm;
        c_in = b.c; op1_in = b.op1; op_sel_in = b.opsel;
    endtask

    // Presents one bundle (stage must be IDLE or HOLD), then waits for out_valid.
    // rdy1 is in_ready one cycle after accept while out_ready is still high.
    task automatic issue(input bundle_t b, output int lat, output logic rdy1);
        drive(b);
        rs_data   = $urandom;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        rs_data   = b.rs;
        rdy1      = in_ready;
        out_ready = 1'b0;
        // Scramble sampled inputs so late sampling in the DUT is visible.
        rm_data = $urandom; c_in = ~c_in; op1_in = $urandom; op_sel_in = 4'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 5) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        drive(mk(1'b1, 8'hFF, 4'd4, 32'h1, 2'd0, 1'b0, 5'd0, 32'h0, 1'b1));
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0; rs_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if ({alu_op1, alu_op2, alu_op_sel, shifter_carry} !== 69'd0) begin
            errors++; $display("FAIL reset_outputs got %h %h %h %b want all 0", alu_op1, alu_op2, alu_op_sel, shifter_carry);
        end
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        bundle_t     tbl[9];
        logic [31:0] eo[9];
        logic        ec[9];
        int          lat;
        logic        rdy1;
        tbl[0] = mk(1'b1, 8'hFF, 4'd4, 32'h0, 2'd0, 1'b0, 5'd0, 32'h0, 1'b0); eo[0] = 32'hFF000000; ec[0] = 1'b1;
        tbl[1] = mk(1'b1, 8'hFF, 4'd0, 32'h0, 2'd0, 1'b1, 5'd0, 32'h0, 1'b0); eo[1] = 32'h000000FF; ec[1] = 1'b0;
        tbl[2] = mk(1'b0, 8'h00, 4'd0, 32'h80000001, 2'd1, 1'b0, 5'd0, 32'h0, 1'b0); eo[2] = 32'h0; ec[2] = 1'b1;
        tbl[3] = mk(1'b0, 8'h00, 4'd0, 32'h80000001, 2'd2, 1'b0, 5'd0, 32'h0, 1'b0); eo[3] = 32'hFFFFFFFF; ec[3] = 1'b1;
        tbl[4] = mk(1'b0, 8'h00, 4'd0, 32'h00000003, 2'd3, 1'b0, 5'd0, 32'h0, 1'b1); eo[4] = 32'h80000001; ec[4] = 1'b1;
        tbl[5] = mk(1'b0, 8'h00, 4'd0, 32'hFFFFFFFF, 2'd0, 1'b1, 5'd0, 32'd33, 1'b1); eo[5] = 32'h0; ec[5] = 1'b0;
        tbl[6] = mk(1'b0, 8'h00, 4'd0, 32'hFFFFFFFF, 2'd0, 1'b1, 5'd0, 32'd32, 1'b0); eo[6] = 32'h0; ec[6] = 1'b1;
        tbl[7] = mk(1'b0, 8'h00, 4'd0, 32'hFFFFFFFF, 2'd0, 1'b1, 5'd0, 32'h100, 1'b0); eo[7] = 32'hFFFFFFFF; ec[7] = 1'b0;
        tbl[8] = mk(1'b0, 8'h00, 4'd0, 32'h12345678, 2'd0, 1'b0, 5'd4, 32'h0, 1'b0); eo[8] = 32'h23456780; ec[8] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            issue(tbl[i], lat, rdy1);
            checks++; if (lat !== ((tbl[i].byreg && !tbl[i].isel) ? 2 : 1)) begin
                errors++; $display("FAIL dir%0d_latency got %0d", i, lat);
            end
            checks++; if (rdy1 !== !(tbl[i].byreg && !tbl[i].isel)) begin
                errors++; $display("FAIL dir%0d_in_ready got %b want %b", i, rdy1, !(tbl[i].byreg && !tbl[i].isel));
            end
            checks++; if (alu_op2 !== eo[i]) begin errors++; $display("FAIL dir%0d_op2 got %h want %h", i, alu_op2, eo[i]); end
            checks++; if (shifter_carry !== ec[i]) begin errors++; $display("FAIL dir%0d_carry got %b want %b", i, shifter_carry, ec[i]); end
            checks++; if (alu_op1 !== 32'hDEADBEEF || alu_op_sel !== 4'hD) begin
                errors++; $display("FAIL dir%0d_passthru got %h %h want deadbeef d", i, alu_op1, alu_op_sel);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic rdy1;
        issue(mk(1'b0, 8'h00, 4'd0, 32'h12345678, 2'd0, 1'b0, 5'd4, 32'h0, 1'b0), lat, rdy1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || alu_op2 !== 32'h23456780 || in_ready !== 1'b0) begin
                errors++; $display("FAIL stall%0d got v=%b op2=%h rdy=%b want 1 23456780 0", i, out_valid, alu_op2, in_ready);
            end
        end
        drive(mk(1'b1, 8'h3F, 4'd1, 32'h0, 2'd0, 1'b0, 5'd0, 32'h0, 1'b0));
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || alu_op2 !== 32'hC000000F || shifter_carry !== 1'b1) begin
            errors++; $display("FAIL b2b_next got v=%b op2=%h c=%b want 1 c000000f 1", out_valid, alu_op2, shifter_carry);
        end
    endtask

    task automatic test_random();
        bundle_t     b;
        logic [32:0] exp;
        int          lat;
        logic        rdy1;
        for (int n = 0; n < 300; n++) begin
            b.isel  = ($urandom_range(0, 3) == 0);
            b.imm8  = 8'($urandom);
            b.rot4  = 4'($urandom);
            b.rm    = $urandom;
            b.st    = 2'($urandom);
            b.byreg = 1'($urandom);
            b.simm  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            b.rs    = ($urandom_range(0, 1) == 0) ? (($urandom & 32'hFFFFFF00) | $urandom_range(0, 40))
                                                  : $urandom;
            b.c     = 1'($urandom);
            b.op1   = $urandom;
            b.opsel = 4'($urandom);
            exp = model(b);
            issue(b, lat, rdy1);
            checks++; if (lat !== ((b.byreg && !b.isel) ? 2 : 1)) begin
                errors++; $display("FAIL rnd%0d_latency got %0d", n, lat);
            end
            checks++; if ({shifter_carry, alu_op2} !== exp) begin
                errors++; $display("FAIL rnd%0d_op2 got %b_%h want %b_%h (st=%0d reg=%b simm=%0d rs=%h rm=%h)",
                                   n, shifter_carry, alu_op2, exp[32], exp[31:0], b.st, b.byreg, b.simm, b.rs, b.rm);
            end
            checks++; if (alu_op1 !== b.op1 || alu_op_sel !== b.opsel) begin
                errors++; $display("FAIL rnd%0d_passthru got %h %h want %h %h", n, alu_op1, alu_op_sel, b.op1, b.opsel);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(mk(1'b0, 8'h00, 4'd0, 32'hFFFFFFFF, 2'd1, 1'b1, 5'd0, 32'h0, 1'b1));
        rs_data = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_state got v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        checks++; if ({alu_op1, alu_op2, alu_op_sel, shifter_carry} !== 69'd0) begin
            errors++; $display("FAIL midreset_outputs got %h %h %h %b want all 0", alu_op1, alu_op2, alu_op_sel, shifter_carry);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_dropped got %b want 0", out_valid); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rs_data = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
